// File: rtl/cn_min_track_pkg.sv
// Shared widths, sentinels, magnitude helper and FSM encoding for the
// check-node minimum tracker and its downstream output stage.
package cn_min_track_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 8;

    localparam logic [DATA_W-1:0] MAG_MAX  = '1;
    localparam logic [IDX_W-1:0]  IDX_NONE = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        ACC   = 1'b1
    } state_t;

    // The most negative code has no positive twin, so it clips to the largest positive value.
    function automatic logic [DATA_W-1:0] sat_mag(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] m;
        if (!d[DATA_W-1])
            m = d;
        else if (d[DATA_W-2:0] == '0)
            m = {1'b0, {(DATA_W-1){1'b1}}};
        else
            m = -d;
        return m;
    endfunction

endpackage

// File: rtl/cn_mag_sat.sv
// Combinational saturating absolute value of a two's complement message.
// Zero latency, no flow control.
module cn_mag_sat #(
    parameter int w = 8
) (
    input  logic [w-1:0] d,
    output logic [w-1:0] mag
);

    always_comb begin
        if (!d[w-1])
            mag = d;
        else if (d[w-2:0] == '0)
            mag = {1'b0, {(w-1){1'b1}}};
        else
            mag = -d;
    end

endmodule

// File: rtl/cn_min_track.sv
// Streaming two-minimum / sign-parity tracker for one check-node row.
// Result one cycle after the closing beat; a held, unconsumed result stalls every input beat.
module cn_min_track
    import cn_min_track_pkg::*;
#(
    parameter int data_w  = DATA_W,
    parameter int idx_w   = IDX_W,
    parameter int max_deg = 32,
    parameter int cnt_w   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_w-1:0]    in_data,
    input  logic [idx_w-1:0]     in_idx,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*data_w-1:0]  out,
    output logic [2*idx_w-1:0]   idx_out,
    output logic                 sign_out,
    output logic [cnt_w-1:0]     deg_out,
    output logic                 ovf_out
);

    logic [data_w-1:0] mag;
    logic [data_w-1:0] min1, min2, min1_n, min2_n;
    logic [idx_w-1:0]  idx1, idx2, idx1_n, idx2_n;
    logic              sign, sign_n;
    logic [cnt_w-1:0]  cnt, cnt_n;
    logic              accept, close;
    state_t            state;

    cn_mag_sat #(.w(data_w)) u_mag (
        .d   (in_data),
        .mag (mag)
    );

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    // Strict compares keep the earlier beat on ties.
    always_comb begin
        min1_n = min1;
        min2_n = min2;
        idx1_n = idx1;
        idx2_n = idx2;
        if (mag < min1) begin
            min2_n = min1;
            idx2_n = idx1;
            min1_n = mag;
            idx1_n = in_idx;
        end else if (mag < min2) begin
            min2_n = mag;
            idx2_n = in_idx;
        end
        sign_n = sign ^ in_data[data_w-1];
        cnt_n  = cnt + cnt_w'(1);
    end

    assign close = accept && (in_last || cnt_n == cnt_w'(max_deg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            min1  <= {data_w{1'b1}};
            min2  <= {data_w{1'b1}};
            idx1  <= {idx_w{1'b1}};
            idx2  <= {idx_w{1'b1}};
            sign  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            if (close) begin
                min1 <= {data_w{1'b1}};
                min2 <= {data_w{1'b1}};
                idx1 <= {idx_w{1'b1}};
                idx2 <= {idx_w{1'b1}};
                sign <= 1'b0;
                cnt  <= '0;
            end else begin
                min1 <= min1_n;
                min2 <= min2_n;
                idx1 <= idx1_n;
                idx2 <= idx2_n;
                sign <= sign_n;
                cnt  <= cnt_n;
            end
            case (state)
                EMPTY:   if (!close) state <= ACC;
                ACC:     if (close) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    // One-slot result buffer; a close in the consume cycle reloads it without a gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            idx_out   <= '0;
            sign_out  <= 1'b0;
            deg_out   <= '0;
            ovf_out   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out       <= {min2_n, min1_n};
            idx_out   <= {idx2_n, idx1_n};
            sign_out  <= sign_n;
            deg_out   <= cnt_n;
            ovf_out   <= !in_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cn_min_track.sv
// Scoreboard bench for cn_min_track: a row-level reference model queues expected
// results and an independent monitor compares every presented output.
module tb_cn_min_track;

    localparam int MAX_DEG = 32;

    typedef struct packed {
        logic [7:0] min2;
        logic [7:0] min1;
        logic [7:0] idx2;
        logic [7:0] idx1;
        logic       sign;
        logic [5:0] deg;
        logic       ovf;
    } res_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  in_data = 0;
    logic [7:0]  in_idx = 0;
    logic        in_last = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [15:0] out;
    logic [15:0] idx_out;
    logic        sign_out;
    logic [5:0]  deg_out;
    logic        ovf_out;

    int n_checks = 0;
    int n_pass = 0;

    res_t exp_q[$];
    int   row_mag[$];
    int   row_idx[$];
    logic row_sign = 0;

    bit   rdy_mode = 0;
    logic rdy_force = 1;
    bit   gap_en = 0;

    cn_min_track dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .idx_out   (idx_out),
        .sign_out  (sign_out),
        .deg_out   (deg_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        out_ready = rdy_mode ? rdy_force : ($urandom_range(0, 9) < 7);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic int abs_sat(input logic [7:0] d);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > 127) v = 127;
        return v;
    endfunction

    // Row-level reference: collect the whole row, then pick the two smallest magnitudes
    // (earliest position wins a tie) once the row closes.
    task automatic model_accept(input logic [7:0] d, input logic [7:0] ix, input logic lst,
                                output bit closed);
        res_t r;
        int   p1, p2;
        row_mag.push_back(abs_sat(d));
        row_idx.push_back(int'(ix));
        row_sign ^= d[7];
        closed = lst || (row_mag.size() == MAX_DEG);
        if (closed) begin
            p1 = 0;
            for (int i = 1; i < row_mag.size(); i++)
                if (row_mag[i] < row_mag[p1]) p1 = i;
            p2 = -1;
            for (int i = 0; i < row_mag.size(); i++)
                if (i != p1 && (p2 < 0 || row_mag[i] < row_mag[p2])) p2 = i;
            r.min1 = 8'(row_mag[p1]);
            r.idx1 = 8'(row_idx[p1]);
            r.min2 = (p2 < 0) ? 8'hFF : 8'(row_mag[p2]);
            r.idx2 = (p2 < 0) ? 8'hFF : 8'(row_idx[p2]);
            r.sign = row_sign;
            r.deg  = 6'(row_mag.size());
            r.ovf  = !lst;
            exp_q.push_back(r);
            row_mag.delete();
            row_idx.delete();
            row_sign = 0;
        end
    endtask

    // Monitor: compare the presented result to the head of the queue every cycle it is valid.
    always @(negedge clk) begin
        #3;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                check("out",      out,      {exp_q[0].min2, exp_q[0].min1});
                check("idx_out",  idx_out,  {exp_q[0].idx2, exp_q[0].idx1});
                check("sign_out", sign_out, exp_q[0].sign);
                check("deg_out",  deg_out,  exp_q[0].deg);
                check("ovf_out",  ovf_out,  exp_q[0].ovf);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [7:0] ix, input logic lst,
                             output bit closed);
        int guard;
        guard = 0;
        closed = 0;
        if (gap_en)
            repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_valid = 1; in_data = d; in_idx = ix; in_last = lst;
        #2;
        while (!in_ready) begin
            @(negedge clk);
            #2;
            guard++;
            if (guard > 300) begin
                check("in_ready_timeout", in_ready, 1'b1);
                in_valid = 0;
                return;
            end
        end
        @(posedge clk);
        model_accept(d, ix, lst, closed);
        #1;
        in_valid = 0;
        in_last = 0;
        if (closed) check("close_latency_vld", out_valid, 1'b1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        row_mag.delete();
        row_idx.delete();
        row_sign = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", {out, idx_out, sign_out, deg_out, ovf_out}, 64'd0);
        check("rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        bit cl;
        logic [7:0] t_data [4];
        t_data[0] = 8'd5; t_data[1] = 8'hFD; t_data[2] = 8'd7; t_data[3] = 8'hFE;

        do_reset();

        // Four-beat row
        rdy_mode = 1; rdy_force = 1;
        for (int i = 0; i < 4; i++) send_beat(t_data[i], 8'(i), i == 3, cl);
        check("t1_out", out, {8'd3, 8'd2});
        check("t1_idx", idx_out, {8'd1, 8'd3});
        check("t1_sign_deg_ovf", {sign_out, deg_out, ovf_out}, {1'b0, 6'd4, 1'b0});

        // Ties keep the earlier beat
        send_beat(8'd4, 8'd9, 0, cl);
        send_beat(8'd4, 8'd8, 0, cl);
        send_beat(8'd4, 8'd7, 1, cl);
        check("tie_out", {out, idx_out}, {8'd4, 8'd4, 8'd8, 8'd9});

        // Single most-negative beat
        send_beat(8'h80, 8'h21, 1, cl);
        check("single_out", {out, idx_out}, {8'hFF, 8'h7F, 8'hFF, 8'h21});
        check("single_sign_deg", {sign_out, deg_out}, {1'b1, 6'd1});

        // Back-to-back with the first result held
        drain();
        rdy_force = 0;
        send_beat(8'd10, 8'd1, 0, cl);
        send_beat(8'hF0, 8'd2, 1, cl);
        fork
            send_beat(8'd6, 8'd3, 1, cl);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_out_held", out, {8'd16, 8'd10});
                end
                rdy_force = 1;
            end
        join
        check("b2b_row2_out", out, {8'hFF, 8'd6});

        // Overflow close after 32 beats, remainder opens a new row
        drain();
        rdy_mode = 0;
        for (int i = 0; i < 34; i++) send_beat(8'($urandom), 8'(i), i == 33, cl);
        drain();

        // Reset mid-row discards the partial row
        send_beat(8'd1, 8'd0, 0, cl);
        send_beat(8'd2, 8'd1, 0, cl);
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(8'(20 + i), 8'(i), i == 2, cl);
        check("post_rst_deg", deg_out, 6'd3);

        // Randomized rows, random gaps and random downstream stalls
        gap_en = 1;
        for (int r = 0; r < 30; r++) begin
            int deg;
            deg = $urandom_range(1, 36);
            for (int b = 0; b < deg; b++)
                send_beat(8'($urandom), 8'($urandom), b == deg - 1, cl);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cn_min_track.md
Name: cn_min_track

Overview:
- Streaming check-node minimum tracker for the min-sum LDPC decoder.
- Accepts one signed variable-to-check message per beat for a row.
- Tracks the two smallest magnitudes, their indices and the sign parity.
- On the row's last beat, emits a sorted pair packed {second, first}, ready to feed the 4-input two-minimum merge stage directly downstream.

Parameters:
data_w, 8, message width (two's complement in, unsigned magnitude out)
idx_w, 8, index width carried with each message
max_deg, 32, maximum row degree; beats beyond this force a row close
cnt_w, 6, beat counter width, must hold max_deg

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  data_w  signed message
in_idx  input  idx_w  message index
in_last  input  1  final beat of row
out_valid  output  1  result held valid
out_ready  input  1  downstream accepts result
out  output  2*data_w  {min2, min1}, min1 <= min2
idx_out  output  2*idx_w  {idx2, idx1}
sign_out  output  1  XOR of sign bits of all row beats
deg_out  output  cnt_w  number of beats in row
ovf_out  output  1  row closed by max_deg, not by in_last

Behaviour:
- Clock, reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset values:
  - out_valid=0; out, idx_out, sign_out, deg_out, ovf_out = 0.
  - Accumulators at sentinel: min1=min2={data_w{1}}, idx1=idx2={idx_w{1}}, sign=0, cnt=0. FSM in EMPTY.
- Magnitude:
  - mag = in_data[data_w-1] ? -in_data : in_data, zero-extended to data_w.
  - Most negative value saturates to 2^(data_w-1)-1, e.g. 8'h80 -> 8'h7F.
- Update on an accepted beat, computed from the current accumulator:
  - if mag < min1: min2<=min1, idx2<=idx1, min1<=mag, idx1<=in_idx.
  - else if mag < min2: min2<=mag, idx2<=in_idx.
  - else: no change.
  - Strict compares, so ties keep the earlier beat.
  - sign ^= in_data[data_w-1]; cnt += 1.
- FSM:
  - EMPTY: first accepted beat -> ACC. If that beat has in_last, the row closes in the same cycle and the FSM stays EMPTY.
  - ACC: accepted beat with in_last, or accepted beat making cnt==max_deg -> close row -> EMPTY.
- Close row:
  - Result register loads the updated values, including the closing beat. out_valid<=1, deg_out=cnt+1, ovf_out = !in_last.
  - Accumulators return to sentinel in the same cycle, so back-to-back rows need no bubble.
- Single-beat row: min2 and idx2 stay at sentinel all-ones.
- Output handshake:
  - One-slot result buffer; out_valid drops one cycle after out_valid && out_ready unless a new row closes the same cycle.
  - Simultaneous consume and new close: the buffer reloads, out_valid stays 1.
  - Outputs are stable while out_valid && !out_ready.
- Backpressure:
  - in_ready = !(out_valid && !out_ready), a combinational path from out_ready.
  - This stalls all beats, not only closing beats, keeping the datapath simple.
- Latency: result visible one cycle after the closing beat's accept edge.
- in_valid low: state held, no change.
- Reset mid-row: the partial row is discarded, no output produced.

Decomposition:
- Shared package:
  - data_w, idx_w defaults.
  - Sentinel constants MAG_MAX and IDX_NONE.
  - Helper function for saturating magnitude.
  - FSM state encoding (EMPTY=0, ACC=1).
- One sub-module, cn_mag_sat: combinational abs with saturation. It is reused by the downstream check-node output stage.

Test Plan:
- Row of 4 beats, data 5,-3,7,-2, idx 0..3, last on beat 4 -> out={8'd3,8'd2}, idx_out={8'd1,8'd3}, sign_out=0, deg_out=4, ovf_out=0, one cycle after the last accept.
- Ties: data 4,4,4, idx 9,8,7 -> min1=4/idx 9, min2=4/idx 8.
- Single beat -128 with last -> out={8'hFF,8'h7F}, idx_out={8'hFF,idx}, sign_out=1, deg_out=1.
- Back-to-back rows with out_ready=0 after the first result:
  - in_ready falls, first result holds stable.
  - Raising out_ready lets row 2 close in the same cycle as consume; out_valid stays high with row 2's result.
- 33 beats without last (max_deg=32) -> close after beat 32 with ovf_out=1, deg_out=32; beat 33 starts a new row.
- Assert rst after 2 beats of a row -> no output; the next 3-beat row reports only its own beats, deg_out=3.
